// File: rtl/collatz_pkg.sv
// Shared types for the sequential Collatz engine: FSM states and result status codes.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_OVF     = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ZERO    = 2'b11
    } status_t;

endpackage

// File: rtl/collatz_seq_if.sv
// Start/result bus of the Collatz engine; master issues requests, slave is the engine.
interface collatz_seq_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     n;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] steps;
    logic [WIDTH-1:0]     peak;
    logic [1:0]           status;

    modport master (output start, n, input busy, done, steps, peak, status);
    modport slave  (input start, n, output busy, done, steps, peak, status);
endinterface

// File: rtl/collatz_step.sv
// One Collatz map step on a WIDTH-bit value; flags results that do not fit back in WIDTH bits.
module collatz_step #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SHORTCUT = 0
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next,
    output logic             ovf
);
    // Two guard bits hold 3x+1 for any WIDTH-bit x.
    localparam int unsigned XW = WIDTH + 2;

    logic [XW-1:0] ext;
    logic [XW-1:0] odd_val;
    logic [XW-1:0] wide;

    always_comb begin
        ext     = XW'(cur);
        odd_val = (ext << 1) + ext + XW'(1);
        if (SHORTCUT != 0) begin
            odd_val = odd_val >> 1;
        end
        wide = cur[0] ? odd_val : (ext >> 1);
        next = wide[WIDTH-1:0];
        ovf  = |wide[XW-1:WIDTH];
    end
endmodule

// File: rtl/collatz_seq.sv
// Sequential Collatz engine: iterates one map step per clock from a captured start value and
// reports stopping time, peak value and a status code (ok / overflow / timeout / zero input).
module collatz_seq
    import collatz_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned SHORTCUT  = 0
) (
    input  logic         clk,
    input  logic         reset,
    collatz_seq_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] STEP_MAX = '1;

    state_t               state, state_nx;
    status_t              status, status_nx;
    logic [WIDTH-1:0]     cur, cur_nx;
    logic [WIDTH-1:0]     peak, peak_nx;
    logic [CNT_WIDTH-1:0] steps, steps_nx;
    logic                 busy, busy_nx;
    logic                 done, done_nx;
    logic [WIDTH-1:0]     step_val;
    logic                 step_ovf;

    collatz_step #(.WIDTH(WIDTH), .SHORTCUT(SHORTCUT)) u_step (
        .cur  (cur),
        .next (step_val),
        .ovf  (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            status <= ST_OK;
            cur    <= '0;
            peak   <= '0;
            steps  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            status <= status_nx;
            cur    <= cur_nx;
            peak   <= peak_nx;
            steps  <= steps_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_nx  = state;
        status_nx = status;
        cur_nx    = cur;
        peak_nx   = peak;
        steps_nx  = steps;
        busy_nx   = busy;
        done_nx   = done;

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    steps_nx = '0;
                    if (bus.n == '0) begin
                        state_nx  = DONE;
                        status_nx = ST_ZERO;
                        peak_nx   = '0;
                        busy_nx   = 1'b0;
                        done_nx   = 1'b1;
                    end else begin
                        state_nx  = RUN;
                        status_nx = ST_OK;
                        cur_nx    = bus.n;
                        peak_nx   = bus.n;
                        busy_nx   = 1'b1;
                        done_nx   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (cur == WIDTH'(1)) begin
                    state_nx  = DONE;
                    status_nx = ST_OK;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                end else if (steps == STEP_MAX) begin
                    state_nx  = DONE;
                    status_nx = ST_TIMEOUT;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                end else if (step_ovf) begin
                    state_nx  = DONE;
                    status_nx = ST_OVF;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                end else begin
                    cur_nx   = step_val;
                    steps_nx = steps + CNT_WIDTH'(1);
                    if (step_val > peak) begin
                        peak_nx = step_val;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b0;
            end
        endcase
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.steps  = steps;
    assign bus.peak   = peak;
    assign bus.status = status;
endmodule

// File: tb/tb_collatz_seq.sv
// Bench for collatz_seq: three configurations run the same start values in lockstep and are
// compared against an arithmetic model of the Collatz iteration.
module tb_collatz_seq;
    localparam int unsigned W  = 8;
    localparam int unsigned ND = 3;
    localparam int unsigned CW [ND] = '{8, 4, 8};
    localparam int unsigned SC [ND] = '{0, 0, 1};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] nval = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    collatz_seq_if #(.WIDTH(8), .CNT_WIDTH(8)) if0 ();
    collatz_seq_if #(.WIDTH(8), .CNT_WIDTH(4)) if1 ();
    collatz_seq_if #(.WIDTH(8), .CNT_WIDTH(8)) if2 ();

    collatz_seq #(.WIDTH(8), .CNT_WIDTH(8), .SHORTCUT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    collatz_seq #(.WIDTH(8), .CNT_WIDTH(4), .SHORTCUT(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    collatz_seq #(.WIDTH(8), .CNT_WIDTH(8), .SHORTCUT(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.start = start;  assign if0.n = nval;
    assign if1.start = start;  assign if1.n = nval;
    assign if2.start = start;  assign if2.n = nval;

    logic        busy_a [ND];
    logic        done_a [ND];
    int unsigned steps_a[ND];
    int unsigned peak_a [ND];
    int unsigned stat_a [ND];

    assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;
    assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;
    assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;
    assign steps_a[0] = 32'(if0.steps);  assign peak_a[0] = 32'(if0.peak);  assign stat_a[0] = 32'(if0.status);
    assign steps_a[1] = 32'(if1.steps);  assign peak_a[1] = 32'(if1.peak);  assign stat_a[1] = 32'(if1.status);
    assign steps_a[2] = 32'(if2.steps);  assign peak_a[2] = 32'(if2.peak);  assign stat_a[2] = 32'(if2.status);

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Plain-integer Collatz iteration: status 0 ok, 1 overflow, 2 timeout, 3 zero.
    task automatic model(input int unsigned nv, input int unsigned cw, input int unsigned sc,
                         output int unsigned st, output int unsigned pk, output int unsigned stat);
        int unsigned x, nx, limit;
        limit = (1 << cw) - 1;
        st = 0;
        pk = nv;
        stat = 3;
        if (nv == 0) begin
            pk = 0;
            return;
        end
        x = nv;
        forever begin
            if (x == 1) begin stat = 0; return; end
            if (st == limit) begin stat = 2; return; end
            if (x % 2 == 0) nx = x / 2;
            else            nx = (sc != 0) ? (3 * x + 1) / 2 : 3 * x + 1;
            if (nx >= (1 << W)) begin stat = 1; return; end
            x = nx;
            st++;
            if (x > pk) pk = x;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("%s busy d%0d", tag, i), 32'(busy_a[i]), 0);
            check($sformatf("%s done d%0d", tag, i), 32'(done_a[i]), 0);
            check($sformatf("%s steps d%0d", tag, i), steps_a[i], 0);
            check($sformatf("%s peak d%0d", tag, i), peak_a[i], 0);
            check($sformatf("%s status d%0d", tag, i), stat_a[i], 0);
        end
    endtask

    // Issue one start (called at a negedge), track busy/done every cycle, then check results.
    task automatic run(input int unsigned nv);
        int unsigned es[ND], ep[ND], est[ND], el[ND], at[ND];
        bit          seen[ND];
        bit          all_seen;
        int unsigned minl;
        minl = 1000;
        for (int i = 0; i < ND; i++) begin
            model(nv, CW[i], SC[i], es[i], ep[i], est[i]);
            el[i]   = (nv == 0) ? 0 : es[i] + 1;
            seen[i] = 1'b0;
            at[i]   = 0;
            if (el[i] < minl) minl = el[i];
        end
        nval  = W'(nv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned c = 0; c < 400; c++) begin
            all_seen = 1'b1;
            for (int i = 0; i < ND; i++) begin
                if (!seen[i]) begin
                    check($sformatf("busy n=%0d d%0d c=%0d", nv, i, c), 32'(busy_a[i]), 32'(c < el[i]));
                    if (done_a[i]) begin
                        seen[i] = 1'b1;
                        at[i]   = c;
                    end
                end
                all_seen &= seen[i];
            end
            if (all_seen) break;
            // Every engine is still iterating at the next edge, so these starts must be ignored.
            if (c < minl) begin
                start = 1'($urandom_range(0, 1));
                nval  = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < ND; i++) begin
            check($sformatf("done seen n=%0d d%0d", nv, i), 32'(seen[i]), 1);
            check($sformatf("latency n=%0d d%0d", nv, i), at[i], el[i]);
        end
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("done held n=%0d d%0d", nv, i), 32'(done_a[i]), 1);
            check($sformatf("busy low n=%0d d%0d", nv, i), 32'(busy_a[i]), 0);
            check($sformatf("steps n=%0d d%0d", nv, i), steps_a[i], es[i]);
            check($sformatf("peak n=%0d d%0d", nv, i), peak_a[i], ep[i]);
            check($sformatf("status n=%0d d%0d", nv, i), stat_a[i], est[i]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("idle");

        run(6);
        run(7);
        run(1);
        run(255);
        run(0);
        run(27);
        run(2);
        for (int k = 0; k < 20; k++) begin
            run($urandom_range(0, 255));
        end

        // Abort a computation mid-flight with reset.
        nval  = W'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs("midrun reset");
        @(negedge clk);
        check_zero_outputs("after reset");
        run(6);
        run(9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
